store_fwd_hist: RTL and testbench
=================================

Name: store_fwd_hist

Overview:
- Parametrised store-data forwarding unit for the MEM stage of the 5-stage RV32 pipeline.
- Replaces single-source WB->MEM forwarding with a DEPTH-entry history of retired register writes.
- A store held in MEM across stall cycles still picks up writes that retired after its operands were read.
- Adds flush handling and a saturating forward-event counter for performance monitoring.

Parameters:
- XLEN, 32, data width of register values.
- DEPTH, 2, history entries of retired writes kept beyond WB; legal range 1..8.
- CNT_W, 16, width of the forward-event counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- Instruction_EXMEM  in  32  instruction in MEM stage; rs2 = [24:20].
- memWrite_EXMEM  in  1  MEM-stage instruction is a store.
- Instruction_MEMWB  in  32  instruction in WB stage; rd = [11:7].
- we_MEMWB  in  1  WB-stage instruction writes rd.
- WB_data  in  XLEN  value being written back this cycle.
- RegData2_EXMEM  in  XLEN  rs2 value latched in EX/MEM.
- flush  in  1  pipeline flush; clears history.
- fwd_data  out  XLEN  store data to the data memory.
- fwd_hit  out  1  forwarding source selected this cycle.
- fwd_cnt  out  CNT_W  saturating count of cycles with fwd_hit=1.

Behaviour:
- Clocking: one clock, clk. Synchronous active-high reset, rst. All state updates on the rising edge of clk.
- WB retire event: `wb_ev = we_MEMWB && rd_MEMWB != 0`.
- History: DEPTH entries of {valid, rd[4:0], data[XLEN]}. Entry 0 is the youngest.
  - On each cycle with wb_ev=1 and flush=0: shift entries down (entry k -> k+1, oldest dropped), load entry 0 = {1, rd_MEMWB, WB_data}.
  - Cycles with wb_ev=0 leave the history unchanged.
  - A rd=x0 write never enters the history.
- Match terms, evaluated only when memWrite_EXMEM=1 and rs2 != 0:
  - `wb_match = wb_ev && rd_MEMWB == rs2`.
  - `h_match[k] = valid[k] && rd[k] == rs2`.
- Priority, youngest wins:
  - wb_match -> WB_data;
  - else lowest k with h_match[k] -> data[k];
  - else RegData2_EXMEM.
- fwd_hit = 1 when either of the first two priority cases is taken.
- fwd_data and fwd_hit are combinational from the current inputs and registered history. Zero-cycle latency.
- Non-store cycles (memWrite_EXMEM=0): fwd_hit=0 and fwd_data=RegData2_EXMEM.
- fwd_cnt: increments by 1 on each cycle with fwd_hit=1, saturating at all-ones. Never wraps. Unaffected by flush.
- flush:
  - Clears every valid[k] at the next edge; the history is empty in the following cycle.
  - Forwarding in the flush cycle itself is still computed normally.
  - flush has priority over a simultaneous wb_ev: the WB write is not captured.
- Reset:
  - valid[*]=0 and fwd_cnt=0 at the edge where rst=1.
  - While rst=1, fwd_hit=0 and fwd_data=RegData2_EXMEM regardless of other inputs.
  - Reset asserted mid-stall discards all history.
- Same rd in several entries: the youngest entry (lowest index) wins. Stale duplicates are harmless and are not invalidated.
- Boundary, DEPTH=1: the history is a single register; the shift degenerates to load.
- Boundary, full history with a new wb_ev: the oldest entry is silently dropped; no overflow flag.

Decomposition:
- Shared pipeline package gets:
  - hist_entry_t struct {valid, rd, data}.
  - Constants for instruction field slices: RS2_LSB=20, RD_LSB=7, REG_W=5.
- One natural sub-module: fwd_prio_sel, a parametrised youngest-first priority mux over DEPTH+1 candidates, returning hit and data.
- The counter stays inline.

Test Plan:
- WB match: store rs2=x5 in MEM; WB writes x5=0xDEADBEEF, we=1 -> fwd_data=0xDEADBEEF, fwd_hit=1, fwd_cnt 0->1.
- Stalled store, history hit: store rs2=x7 held in MEM. Cycle 0: WB writes x7=0x11. Cycles 1-2: no WB write. -> fwd_data=0x11 on cycles 0, 1 and 2; fwd_cnt=3.
- Priority: history holds x3=0xA (entry 1) and x3=0xB (entry 0); WB writes x3=0xC -> 0xC. Next cycle, with no WB write -> 0xC.
- x0 and non-store: WB writes x0=0xFF with store rs2=x0 -> fwd_data=RegData2_EXMEM, fwd_hit=0. Hit conditions present but memWrite=0 -> fwd_hit=0.
- Flush: history holds x9=0x55; flush=1 with simultaneous WB write x9=0x66. Next cycle, store rs2=x9 with no WB write -> RegData2_EXMEM, fwd_hit=0.
- Saturation and reset, CNT_W=4: 20 consecutive hits -> fwd_cnt=15. rst=1 for one cycle -> fwd_cnt=0, history empty, fwd_hit=0 during reset.

Source files
------------

// File: rtl/store_fwd_hist_pkg.sv
// Shared pipeline definitions for MEM-stage store-data forwarding:
// instruction field positions and the retired-write history entry.
package store_fwd_hist_pkg;

  localparam int REG_W     = 5;
  localparam int RS2_LSB   = 20;
  localparam int RD_LSB    = 7;
  // Storage width of a history entry; the RV32 pipeline uses XLEN up to this.
  localparam int HIST_XLEN = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_W-1:0]     rd;
    logic [HIST_XLEN-1:0] data;
  } hist_entry_t;

  function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] insn);
    return insn[RS2_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rd_of(input logic [31:0] insn);
    return insn[RD_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/store_fwd_hist_fwd_prio_sel.sv
// Youngest-first priority mux: candidate 0 is the youngest and wins over
// every higher index; hit reports whether any candidate requested.
module fwd_prio_sel #(
  parameter int N  = 3,
  parameter int DW = 32
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0][DW-1:0] cand,
  output logic                 hit,
  output logic [DW-1:0]        data
);

  always_comb begin
    hit  = |req;
    data = '0;
    // Walk oldest to youngest so the lowest requesting index is left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) data = cand[i];
    end
  end

endmodule

// File: rtl/store_fwd_hist.sv
// MEM-stage store-data forwarding from the WB write plus a DEPTH-entry history
// of retired register writes, with flush clearing and a saturating hit counter.
module store_fwd_hist
  import store_fwd_hist_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction_EXMEM,
  input  logic             memWrite_EXMEM,
  input  logic [31:0]      Instruction_MEMWB,
  input  logic             we_MEMWB,
  input  logic [XLEN-1:0]  WB_data,
  input  logic [XLEN-1:0]  RegData2_EXMEM,
  input  logic             flush,
  output logic [XLEN-1:0]  fwd_data,
  output logic             fwd_hit,
  output logic [CNT_W-1:0] fwd_cnt
);

  hist_entry_t [DEPTH-1:0] hist_q, hist_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [REG_W-1:0]             rs2, rd_wb;
  logic                         wb_ev, store_ok;
  logic [DEPTH:0]               cand_req;
  logic [DEPTH:0][XLEN-1:0]     cand_data;
  logic                         sel_hit;
  logic [XLEN-1:0]              sel_data;

  // Only the register fields of the two instruction words are decoded here.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{Instruction_EXMEM, Instruction_MEMWB};

  always_comb begin
    rs2      = rs2_of(Instruction_EXMEM);
    rd_wb    = rd_of(Instruction_MEMWB);
    wb_ev    = we_MEMWB && (rd_wb != '0);
    store_ok = memWrite_EXMEM && (rs2 != '0) && !rst;
  end

  // Candidate 0 is the write retiring this cycle; history entry k follows as k+1.
  always_comb begin
    cand_req     = '0;
    cand_data    = '0;
    cand_req[0]  = wb_ev && (rd_wb == rs2);
    cand_data[0] = WB_data;
    for (int k = 0; k < DEPTH; k++) begin
      cand_req[k+1]  = hist_q[k].valid && (hist_q[k].rd == rs2);
      cand_data[k+1] = hist_q[k].data[XLEN-1:0];
    end
  end

  fwd_prio_sel #(
    .N  (DEPTH + 1),
    .DW (XLEN)
  ) u_prio (
    .req  (cand_req),
    .cand (cand_data),
    .hit  (sel_hit),
    .data (sel_data)
  );

  always_comb begin
    fwd_hit  = store_ok && sel_hit;
    fwd_data = fwd_hit ? sel_data : RegData2_EXMEM;
    fwd_cnt  = cnt_q;
  end

  // Flush wins over a simultaneous retire; stale duplicate rds are left in place.
  always_comb begin
    hist_d = hist_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) hist_d[k].valid = 1'b0;
    end else if (wb_ev) begin
      for (int k = DEPTH - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
      hist_d[0].valid = 1'b1;
      hist_d[0].rd    = rd_wb;
      hist_d[0].data  = HIST_XLEN'(WB_data);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fwd_hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    hist_q <= hist_d;
    cnt_q  <= cnt_d;
    if (rst) begin
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) hist_q[k].valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_fwd_hist.sv
// Bench for store_fwd_hist: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_store_fwd_hist;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [31:0]      Instruction_EXMEM;
  logic             memWrite_EXMEM;
  logic [31:0]      Instruction_MEMWB;
  logic             we_MEMWB;
  logic [XLEN-1:0]  WB_data;
  logic [XLEN-1:0]  RegData2_EXMEM;
  logic             flush;
  logic [XLEN-1:0]  fwd_data;
  logic             fwd_hit;
  logic [CNT_W-1:0] fwd_cnt;

  store_fwd_hist #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .Instruction_EXMEM (Instruction_EXMEM),
    .memWrite_EXMEM    (memWrite_EXMEM),
    .Instruction_MEMWB (Instruction_MEMWB),
    .we_MEMWB          (we_MEMWB),
    .WB_data           (WB_data),
    .RegData2_EXMEM    (RegData2_EXMEM),
    .flush             (flush),
    .fwd_data          (fwd_data),
    .fwd_hit           (fwd_hit),
    .fwd_cnt           (fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: retired writes, youngest at the front of the queue.
  logic [4:0]      m_rd[$];
  logic [XLEN-1:0] m_dat[$];
  int              m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval(output logic hit, output logic [XLEN-1:0] data);
    logic [4:0] rs2, rd;
    rs2  = Instruction_EXMEM[24:20];
    rd   = Instruction_MEMWB[11:7];
    hit  = 1'b0;
    data = RegData2_EXMEM;
    if (!rst && memWrite_EXMEM && rs2 != 0) begin
      if (we_MEMWB && rd != 0 && rd == rs2) begin
        hit  = 1'b1;
        data = WB_data;
      end else begin
        for (int i = 0; i < m_rd.size(); i++) begin
          if (m_rd[i] == rs2) begin
            hit  = 1'b1;
            data = m_dat[i];
            break;
          end
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    logic h;
    logic [XLEN-1:0] d;
    logic [4:0] rd;
    model_eval(h, d);
    rd = Instruction_MEMWB[11:7];
    if (rst) begin
      m_rd.delete();
      m_dat.delete();
      m_cnt = 0;
    end else begin
      if (h && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        m_rd.delete();
        m_dat.delete();
      end else if (we_MEMWB && rd != 0) begin
        m_rd.push_front(rd);
        m_dat.push_front(WB_data);
        if (m_rd.size() > DEPTH) begin
          void'(m_rd.pop_back());
          void'(m_dat.pop_back());
        end
      end
    end
  end

  always @(negedge clk) begin
    logic h;
    logic [XLEN-1:0] d;
    if (chk_en) begin
      model_eval(h, d);
      check("model_hit",  64'(fwd_hit),  64'(h));
      check("model_data", 64'(fwd_data), 64'(d));
      check("model_cnt",  64'(fwd_cnt),  64'(m_cnt));
    end
  end

  // One cycle: drive after the rising edge, settle to the falling edge.
  task automatic step(input logic r, input logic mw, input logic [4:0] rs2,
                      input logic w, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [31:0] r2, input logic fl);
    logic [31:0] ie, iw;
    @(posedge clk);
    #1;
    ie = $urandom;
    iw = $urandom;
    ie[24:20] = rs2;
    iw[11:7]  = rd;
    rst               = r;
    memWrite_EXMEM    = mw;
    Instruction_EXMEM = ie;
    we_MEMWB          = w;
    Instruction_MEMWB = iw;
    WB_data           = wd;
    RegData2_EXMEM    = r2;
    flush             = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; memWrite_EXMEM = 1'b0; we_MEMWB = 1'b0; flush = 1'b0;
    Instruction_EXMEM = '0; Instruction_MEMWB = '0; WB_data = '0; RegData2_EXMEM = '0;

    // Reset with live hit conditions: forwarding must stay off.
    step(1, 1, 5'd5, 1, 5'd5, 32'hAAAA_0001, 32'h0000_0777, 0);
    step(1, 1, 5'd5, 1, 5'd5, 32'hAAAA_0002, 32'h0000_0778, 0);
    check("rst_hit",  64'(fwd_hit),  64'd0);
    check("rst_data", 64'(fwd_data), 64'h778);
    chk_en = 1'b1;

    step(0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0);
    check("rst_cnt", 64'(fwd_cnt), 64'd0);

    // WB match.
    step(0, 1, 5'd5, 1, 5'd5, 32'hDEAD_BEEF, 32'h1111_1111, 0);
    check("wb_data", 64'(fwd_data), 64'hDEAD_BEEF);
    check("wb_hit",  64'(fwd_hit),  64'd1);
    step(0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0);
    check("wb_cnt", 64'(fwd_cnt), 64'd1);

    // Stalled store picks up a write that has moved into the history.
    step(0, 1, 5'd7, 1, 5'd7, 32'h11, 32'h2222, 0);
    check("stall_c0", 64'(fwd_data), 64'h11);
    step(0, 1, 5'd7, 0, 5'd7, 32'h99, 32'h2222, 0);
    check("stall_c1", 64'(fwd_data), 64'h11);
    step(0, 1, 5'd7, 0, 5'd0, 32'h98, 32'h2222, 0);
    check("stall_c2", 64'(fwd_data), 64'h11);
    step(0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0);
    check("stall_cnt", 64'(fwd_cnt), 64'd4);

    // Youngest wins: WB over entry 0 over entry 1.
    step(0, 0, 5'd3, 1, 5'd3, 32'hA, 32'h0, 0);
    step(0, 0, 5'd3, 1, 5'd3, 32'hB, 32'h0, 0);
    step(0, 1, 5'd3, 1, 5'd3, 32'hC, 32'h3333, 0);
    check("prio_wb", 64'(fwd_data), 64'hC);
    step(0, 1, 5'd3, 0, 5'd3, 32'hD, 32'h3333, 0);
    check("prio_hist", 64'(fwd_data), 64'hC);

    // x0 never forwards; non-store never forwards.
    step(0, 1, 5'd0, 1, 5'd0, 32'hFF, 32'h1234, 0);
    check("x0_data", 64'(fwd_data), 64'h1234);
    check("x0_hit",  64'(fwd_hit),  64'd0);
    step(0, 0, 5'd3, 1, 5'd3, 32'hE, 32'h5678, 0);
    check("nst_hit",  64'(fwd_hit),  64'd0);
    check("nst_data", 64'(fwd_data), 64'h5678);

    // Flush: forwarding still works in the flush cycle, history empty after.
    step(0, 0, 5'd0, 1, 5'd9, 32'h55, 32'h0, 0);
    step(0, 1, 5'd9, 1, 5'd9, 32'h66, 32'h4444, 1);
    check("fl_same", 64'(fwd_data), 64'h66);
    step(0, 1, 5'd9, 0, 5'd9, 32'h77, 32'h4444, 0);
    check("fl_data", 64'(fwd_data), 64'h4444);
    check("fl_hit",  64'(fwd_hit),  64'd0);

    // Saturation, then reset mid-stream.
    for (int i = 0; i < 20; i++) step(0, 1, 5'd9, 1, 5'd9, 32'(i), 32'h0, 0);
    step(0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0);
    check("sat_cnt", 64'(fwd_cnt), 64'(CNT_MAX));
    step(1, 1, 5'd9, 1, 5'd9, 32'h5A, 32'h8888, 0);
    check("rst2_hit", 64'(fwd_hit), 64'd0);
    step(0, 1, 5'd9, 0, 5'd9, 32'h0, 32'h9999, 0);
    check("rst2_cnt",  64'(fwd_cnt),  64'd0);
    check("rst2_data", 64'(fwd_data), 64'h9999);

    // Randomized traffic over a narrow register range to provoke hits.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 4)), ($urandom_range(0, 9) < 6),
           5'($urandom_range(0, 4)), $urandom, $urandom,
           ($urandom_range(0, 99) < 5));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
